// File: rtl/sm83_alu_seq.sv
// Slice-serial SM83 ALU: one ALU_WIDTH-bit carry-chain pass per clock, SLICES passes per word.
// Define SM83_ALU_DAA_EN to compile in decimal adjust (opcode 10) for the 4x2 geometry.
module sm83_alu_seq #(
  parameter int  ALU_WIDTH = 4,
  parameter int  SLICES    = 2,
  localparam int WORD_SIZE = ALU_WIDTH * SLICES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 carry_in,
  input  logic                 sub_in,
  input  logic                 half_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry,
  output logic                 halfcarry,
  output logic                 zero
);

  localparam int               CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SLICES - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [2:0] {M_SUM, M_AND, M_XOR, M_OR, M_PASS} mode_t;
  typedef enum logic [2:0] {F_ADD, F_SUB, F_INC, F_DEC, F_AND, F_CLR, F_KEEP, F_DAA} flag_t;

  state_t                 state, state_nxt;
  logic                   accept, last;
  logic [CNT_W-1:0]       cnt_p0;

  // Operands captured at accept; B is already transformed into B'
  logic [WORD_SIZE-1:0]   a_p0, bp_p0, work_p0;
  mode_t                  mode_p0;
  flag_t                  flag_p0;
  logic                   keep_a_p0, cy_in_p0, daa_cy_p0, chain_p0, h0_p0;

  mode_t                  mode_d;
  flag_t                  flag_d;
  logic [WORD_SIZE-1:0]   bp_d;
  logic                   cin_d, keep_a_d, daa_cy_d;

  int                     base;
  logic [ALU_WIDTH-1:0]   a_sl, b_sl, s_sum;
  logic                   c_out;
  logic [WORD_SIZE-1:0]   word_nxt, res_fin;
  logic [1:0]             flags_fin;

  function automatic logic [ALU_WIDTH-1:0] slice_out(input mode_t m,
      input logic [ALU_WIDTH-1:0] x, input logic [ALU_WIDTH-1:0] y,
      input logic [ALU_WIDTH-1:0] s);
    case (m)
      M_SUM:   return s;
      M_AND:   return x & y;
      M_XOR:   return x ^ y;
      M_OR:    return x | y;
      default: return x;
    endcase
  endfunction

  // Returns {C, H}; subtract-type classes report borrows, i.e. inverted carries
  function automatic logic [1:0] final_flags(input flag_t f, input logic msb_c,
      input logic h0, input logic cy_in, input logic daa_cy);
    case (f)
      F_ADD:   return {msb_c, h0};
      F_SUB:   return {~msb_c, ~h0};
      F_INC:   return {cy_in, h0};
      F_DEC:   return {cy_in, ~h0};
      F_AND:   return 2'b01;
      F_CLR:   return 2'b00;
      F_DAA:   return {daa_cy, 1'b0};
      default: return {cy_in, 1'b0};
    endcase
  endfunction

`ifdef SM83_ALU_DAA_EN
  localparam bit DAA_OK = (ALU_WIDTH == 4) && (SLICES == 2);
  logic [8:0] corr;

  // Returns {high-nibble correction applied, correction byte}
  function automatic logic [8:0] daa_corr(input logic [7:0] acc, input logic n,
      input logic h, input logic c);
    logic hi, lo;
    hi = n ? c : (c || (acc > 8'h99));
    lo = n ? h : (h || (acc[3:0] > 4'd9));
    return {hi, (hi ? 4'h6 : 4'h0), (lo ? 4'h6 : 4'h0)};
  endfunction
`else
  logic unused_daa_inputs;
  assign unused_daa_inputs = ^{sub_in, half_in};
`endif

  always_comb begin
    mode_d   = M_PASS;
    flag_d   = F_KEEP;
    bp_d     = '0;
    cin_d    = 1'b0;
    keep_a_d = 1'b0;
    daa_cy_d = 1'b0;
`ifdef SM83_ALU_DAA_EN
    corr     = '0;
`endif
    case (opcode)
      OP_ADD: begin mode_d = M_SUM; flag_d = F_ADD; bp_d = b; end
      OP_ADC: begin mode_d = M_SUM; flag_d = F_ADD; bp_d = b; cin_d = carry_in; end
      OP_SUB: begin mode_d = M_SUM; flag_d = F_SUB; bp_d = ~b; cin_d = 1'b1; end
      OP_SBC: begin mode_d = M_SUM; flag_d = F_SUB; bp_d = ~b; cin_d = ~carry_in; end
      OP_CP:  begin mode_d = M_SUM; flag_d = F_SUB; bp_d = ~b; cin_d = 1'b1; keep_a_d = 1'b1; end
      OP_AND: begin mode_d = M_AND; flag_d = F_AND; bp_d = b; end
      OP_XOR: begin mode_d = M_XOR; flag_d = F_CLR; bp_d = b; end
      OP_OR:  begin mode_d = M_OR;  flag_d = F_CLR; bp_d = b; end
      OP_INC: begin mode_d = M_SUM; flag_d = F_INC; cin_d = 1'b1; end
      OP_DEC: begin mode_d = M_SUM; flag_d = F_DEC; bp_d = '1; end
`ifdef SM83_ALU_DAA_EN
      4'd10: if (DAA_OK) begin
        corr     = daa_corr(8'(a), sub_in, half_in, carry_in);
        mode_d   = M_SUM;
        flag_d   = F_DAA;
        bp_d     = sub_in ? WORD_SIZE'(~corr[7:0]) : WORD_SIZE'(corr[7:0]);
        cin_d    = sub_in;
        daa_cy_d = carry_in | (~sub_in & corr[8]);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: if (cnt_p0 == LAST) begin
        last      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_p0 <= '0;
    else if (accept)        cnt_p0 <= '0;
    else if (busy && !last) cnt_p0 <= cnt_p0 + 1'b1;
  end

  // Slice k: core pass through the shared carry chain
  always_comb begin
    base     = int'(cnt_p0) * ALU_WIDTH;
    a_sl     = a_p0[base +: ALU_WIDTH];
    b_sl     = bp_p0[base +: ALU_WIDTH];
    {c_out, s_sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{ALU_WIDTH{1'b0}}, chain_p0};
    word_nxt = work_p0;
    word_nxt[base +: ALU_WIDTH] = slice_out(mode_p0, a_sl, b_sl, s_sum);
    res_fin   = keep_a_p0 ? a_p0 : word_nxt;
    flags_fin = final_flags(flag_p0, c_out, h0_p0, cy_in_p0, daa_cy_p0);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0      <= a;
      bp_p0     <= bp_d;
      mode_p0   <= mode_d;
      flag_p0   <= flag_d;
      keep_a_p0 <= keep_a_d;
      cy_in_p0  <= carry_in;
      daa_cy_p0 <= daa_cy_d;
      chain_p0  <= cin_d;
    end else if (busy) begin
      chain_p0 <= c_out;
      work_p0  <= word_nxt;
      if (cnt_p0 == '0) h0_p0 <= c_out;
    end
  end

  // Completion: only the final word ever reaches the visible outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      halfcarry <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        result    <= res_fin;
        carry     <= flags_fin[1];
        halfcarry <= flags_fin[0];
        zero      <= (word_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Directed bench for sm83_alu_seq: 8-bit (2 slice) and 16-bit (4 slice) instances.
module tb_sm83_alu_seq;

  logic        clk, reset;
  logic        start2, start4;
  logic [3:0]  opcode;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        carry_in, sub_in, half_in;

  logic        busy2, done2, c2, h2, z2;
  logic [7:0]  res2;
  logic        busy4, done4, c4, h4, z4;
  logic [15:0] res4;

  int n_cmp = 0;
  int n_err = 0;

  sm83_alu_seq #(.ALU_WIDTH(4), .SLICES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .opcode(opcode), .a(a8), .b(b8),
    .carry_in(carry_in), .sub_in(sub_in), .half_in(half_in),
    .busy(busy2), .done(done2), .result(res2), .carry(c2), .halfcarry(h2), .zero(z2));

  sm83_alu_seq #(.ALU_WIDTH(4), .SLICES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .opcode(opcode), .a(a16), .b(b16),
    .carry_in(carry_in), .sub_in(sub_in), .half_in(half_in),
    .busy(busy4), .done(done4), .result(res4), .carry(c4), .halfcarry(h4), .zero(z4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run2(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic n, input logic h, input string tag);
    int lat;
    opcode = op; a8 = av; b8 = bv; carry_in = ci; sub_in = n; half_in = h;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start2 = 1'b0; start4 = 1'b0; opcode = 4'd0;
    a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
    carry_in = 1'b0; sub_in = 1'b0; half_in = 1'b0;
    tick();
    tick();
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_result", res2, 8'h00);
    check("rst_flags", {c2, h2, z2}, 3'b000);
    reset = 1'b0;
    tick();

    // ADD 0x3A + 0xC6 = 0x100
    run2(4'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0, "add");
    check("add_result", res2, 8'h00);
    check("add_chz", {c2, h2, z2}, 3'b111);
    check("add_busy_at_done", busy2, 0);
    tick();
    check("add_done_one_cycle", done2, 0);
    check("add_result_held", res2, 8'h00);

    // SBC 0x10 - 0x01 - 1 = 0x0E
    run2(4'd3, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, "sbc");
    check("sbc_result", res2, 8'h0E);
    check("sbc_chz", {c2, h2, z2}, 3'b010);

    // CP keeps A, flags from A-B
    run2(4'd7, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0, "cp");
    check("cp_result", res2, 8'h42);
    check("cp_chz", {c2, h2, z2}, 3'b001);

    // DAA on 0x7D: +0x06 when compiled in, pass-through otherwise
    run2(4'd10, 8'h7D, 8'h00, 1'b0, 1'b0, 1'b0, "daa");
`ifdef SM83_ALU_DAA_EN
    check("daa_result", res2, 8'h83);
`else
    check("daa_result", res2, 8'h7D);
`endif
    check("daa_chz", {c2, h2, z2}, 3'b000);

    run2(4'd4, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, "and");
    check("and_result", res2, 8'h30);
    check("and_chz", {c2, h2, z2}, 3'b010);

    run2(4'd5, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, "xor");
    check("xor_result", res2, 8'h00);
    check("xor_chz", {c2, h2, z2}, 3'b001);

    run2(4'd6, 8'h81, 8'h14, 1'b0, 1'b0, 1'b0, "or");
    check("or_result", res2, 8'h95);
    check("or_chz", {c2, h2, z2}, 3'b000);

    // Illegal opcode: result A, C = carry_in, H = 0
    run2(4'd12, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, "ill");
    check("ill_result", res2, 8'h00);
    check("ill_chz", {c2, h2, z2}, 3'b101);

    // Back-to-back INC then DEC issued in the done cycle
    run2(4'd8, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "inc");
    check("inc_result", res2, 8'h00);
    check("inc_chz", {c2, h2, z2}, 3'b111);
    opcode = 4'd9; a8 = 8'h00; carry_in = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("b2b_accepted_busy", busy2, 1);
    check("b2b_gap1_done", done2, 0);
    tick();
    check("b2b_gap2_done", done2, 0);
    tick();
    check("b2b_second_done", done2, 1);
    check("dec_result", res2, 8'hFF);
    check("dec_chz", {c2, h2, z2}, 3'b010);

    // 16-bit ADD with an ignored start while busy
    opcode = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001; carry_in = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("w16_busy", busy4, 1);
    opcode = 4'd4; a16 = 16'h0000; b16 = 16'h0000;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 1;
    while (done4 !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check("w16_latency", lat, 4);
    check("w16_result", res4, 16'h0000);
    check("w16_chz", {c4, h4, z4}, 3'b111);
    tick();
    tick();
    check("w16_no_extra_busy", busy4, 0);
    check("w16_no_extra_done", done4, 0);

    // Asynchronous reset mid-RUN
    opcode = 4'd0; a8 = 8'h3A; b8 = 8'h11; carry_in = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check("mid_busy_before", busy2, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_done", done2, 0);
    check("mid_rst_result", res2, 8'h00);
    check("mid_rst_flags", {c2, h2, z2}, 3'b000);
    tick();
    reset = 1'b0;
    check("mid_rst_no_done", done2, 0);
    tick();
    check("post_rst_done", done2, 0);
    check("post_rst_busy", busy2, 0);
    run2(4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "post");
    check("post_result", res2, 8'h03);
    check("post_chz", {c2, h2, z2}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
